// File: rtl/padd_pkg.sv
// -----------------------------------------------------------------------------
// padd_pkg
// Shared helpers for the pipelined adder:
//   padd_slice_w : width of one pipeline slice (WIDTH / STAGES)
//   padd_legal   : configuration legality (STAGES in 1..WIDTH, WIDTH % STAGES == 0)
//   padd_b_off   : bit offset of stage k's remaining-B field in the flattened
//                  B-operand pipeline register
// No ports (package).
// -----------------------------------------------------------------------------
package padd_pkg;

  function automatic int padd_slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit padd_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Stage j keeps the B bits it has not consumed yet: WIDTH-(j+1)*SLICE_W bits.
  // The fields are packed back to back, so stage k starts at the sum of the
  // widths of stages 0..k-1.
  function automatic int padd_b_off(input int width, input int slice_w, input int k);
    return k * width - (slice_w * k * (k + 1)) / 2;
  endfunction

endpackage

// File: rtl/adder_slice_v.sv
// -----------------------------------------------------------------------------
// adder_slice_v
// Combinational SLICE_W-bit ripple-carry adder built from full_adder_v cells.
// Ports:
//   a_i, b_i  [SLICE_W-1:0] operand slices
//   cin_i     carry into bit 0 of the slice
//   s_o       [SLICE_W-1:0] slice sum
//   cout_o    carry out of the top bit of the slice
// -----------------------------------------------------------------------------
module adder_slice_v #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               cout_o
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    full_adder_v u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .s_o    (s_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o = carry[SLICE_W];

endmodule

// File: rtl/full_adder_v.sv
// -----------------------------------------------------------------------------
// full_adder_v
// One-bit full adder.
// Ports:
//   a_i, b_i  operand bits
//   cin_i     carry in
//   s_o       sum bit
//   cout_o    carry out
// -----------------------------------------------------------------------------
module full_adder_v (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder_v.sv
// -----------------------------------------------------------------------------
// pipelined_adder_v
// WIDTH-bit adder split into STAGES slices; one slice is added per stage and the
// carry is registered between stages, so throughput is one add per cycle and
// latency is STAGES cycles (accept edge counted as the first).
//
// Optional feature: define PADD_OVF_EN to produce the signed-overflow flag on
// o_ovf. Without it o_ovf is tied to 0 and no sign logic exists.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready input beat handshake
//   i_a, i_b         [WIDTH-1:0] operands
//   i_carry          carry into bit 0
//   o_valid, i_ready output beat handshake
//   o_s              [WIDTH-1:0] (i_a + i_b + i_carry) mod 2^WIDTH
//   o_carry          carry out of bit WIDTH-1
//   o_ovf            signed overflow (PADD_OVF_EN only, else 0)
//
// Handshake: a beat enters when i_valid & o_ready at a rising edge and leaves
// when o_valid & i_ready. The only stall source is a valid result that the
// sink refuses (o_valid & !i_ready); then every stage holds, bubbles included,
// and o_ready drops. The source keeps its operands steady while refused.
// -----------------------------------------------------------------------------
module pipelined_adder_v
  import padd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int SLICE_W = padd_slice_w(WIDTH, STAGES);
  localparam int B_TOT   = padd_b_off(WIDTH, SLICE_W, STAGES - 1);
  localparam int B_W     = (B_TOT > 0) ? B_TOT : 1;

  if (!padd_legal(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder_v: illegal WIDTH=%0d STAGES=%0d (need 1<=STAGES<=WIDTH, WIDTH%%STAGES==0)",
           WIDTH, STAGES);
  end

  // Per-stage state. sa_q holds, per stage, a WIDTH-bit word whose completed
  // low slices are sum bits and whose upper slices are still operand A, so a
  // beat's result bits always travel together. b_q holds the not-yet-used
  // upper slices of B for every stage, packed back to back.
  logic [STAGES-1:0]       v_q,  v_d;
  logic [STAGES-1:0]       c_q,  c_d;
  logic [STAGES*WIDTH-1:0] sa_q, sa_d;
  logic [B_W-1:0]          b_q,  b_d;
  logic                    stall;

  assign stall   = v_q[STAGES-1] & ~i_ready;
  assign o_ready = ~stall;

  // Valid chain: bubbles shift along with beats; nothing moves during a stall.
  always_comb begin
    v_d    = v_q << 1;
    v_d[0] = i_valid;
  end

`ifdef PADD_OVF_EN
  logic ovf_d;
  logic ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BIN_W = WIDTH - k * SLICE_W;

    logic [WIDTH-1:0]   sa_in;
    logic [BIN_W-1:0]   b_in;
    logic               cin;
    logic [SLICE_W-1:0] sl_sum;
    logic [WIDTH-1:0]   sa_nx;

    if (k == 0) begin : g_first
      assign sa_in = i_a;
      assign b_in  = i_b;
      assign cin   = i_carry;
    end else begin : g_next
      assign sa_in = sa_q[(k-1)*WIDTH +: WIDTH];
      assign b_in  = b_q[padd_b_off(WIDTH, SLICE_W, k - 1) +: BIN_W];
      assign cin   = c_q[k-1];
    end

    adder_slice_v #(
      .SLICE_W (SLICE_W)
    ) u_slice (
      .a_i    (sa_in[k*SLICE_W +: SLICE_W]),
      .b_i    (b_in[SLICE_W-1:0]),
      .cin_i  (cin),
      .s_o    (sl_sum),
      .cout_o (c_d[k])
    );

    // Slice k of A is replaced by its sum; everything else passes through.
    always_comb begin
      sa_nx                       = sa_in;
      sa_nx[k*SLICE_W +: SLICE_W] = sl_sum;
    end

    assign sa_d[k*WIDTH +: WIDTH] = sa_nx;

    if (k < STAGES - 1) begin : g_bfwd
      assign b_d[padd_b_off(WIDTH, SLICE_W, k) +: (BIN_W - SLICE_W)] = b_in[BIN_W-1:SLICE_W];
    end

`ifdef PADD_OVF_EN
    // In the last stage sa_in[WIDTH-1] is still A's sign bit and b_in's top
    // bit is B's sign bit; the slice sum's top bit is the result sign.
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = (sa_in[WIDTH-1] == b_in[SLICE_W-1]) &
                     (sl_sum[SLICE_W-1] != sa_in[WIDTH-1]);
    end
`endif
  end

  if (STAGES == 1) begin : g_no_b
    assign b_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      sa_q <= '0;
      b_q  <= '0;
    end else if (!stall) begin
      v_q  <= v_d;
      c_q  <= c_d;
      sa_q <= sa_d;
      b_q  <= b_d;
    end
  end

`ifdef PADD_OVF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= ovf_d;
    end
  end

  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_valid = v_q[STAGES-1];
  assign o_s     = sa_q[(STAGES-1)*WIDTH +: WIDTH];
  assign o_carry = c_q[STAGES-1];

endmodule
